// File: rtl/mfe_lcd1602_sequencer.sv
// mfe_lcd1602_sequencer: command source for mfe_lcd1602_controller.
// Waits out the HD44780 power-on time, sends the init sequence, then renders a
// 2x16 character buffer on each refresh request, one controller transfer at a time.
//
// state   | meaning
// S_PWR   | power-on settling wait
// S_INIT  | sending function set / display on / entry mode / clear
// S_FRAME | sending line addresses and the 32 buffer bytes
// S_IDLE  | frame done, waiting for refresh
//
// hs      | meaning
// H_ISSUE | wait for ready, then pulse vld with the current step's byte
// H_ACK   | controller has not yet dropped ready
// H_DONE  | wait for ready to return, then advance step
module mfe_lcd1602_sequencer #(
    parameter int unsigned T_PWR        = 4000000,
    parameter int unsigned T_PWR_WIDTH  = 22,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    output logic       lcd_cmd,
    output logic [7:0] lcd_dat,
    output logic       lcd_vld,
    output logic       lcd_lwt,
    input  logic       lcd_ready,
    output logic       busy,
    output logic       init_done
);

    typedef enum logic [1:0] {S_PWR, S_INIT, S_FRAME, S_IDLE} state_t;
    typedef enum logic [1:0] {H_ISSUE, H_ACK, H_DONE} hs_t;

    localparam logic [T_PWR_WIDTH-1:0] PWR_LAST = T_PWR_WIDTH'(T_PWR - 1);

    state_t                 state_q, state_d;
    hs_t                    hs_q, hs_d;
    logic [5:0]             step_q, step_d;
    logic [T_PWR_WIDTH-1:0] pwr_cnt_q, pwr_cnt_d;
    logic                   pend_q, pend_d;
    logic                   init_done_q, init_done_d;
    logic                   busy_q, busy_d;
    logic                   vld_q, vld_d;
    logic                   cmd_q, cmd_d;
    logic [7:0]             dat_q, dat_d;
    logic                   lwt_q, lwt_d;
    logic [7:0]             buf_q [32];
    logic [7:0]             buf_d [32];

    logic                   xfer_cmd;
    logic [7:0]             xfer_dat;
    logic                   xfer_lwt;
    logic                   xfer_last;
    logic [5:0]             buf_idx;

    // Character buffer write port; open in every state.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) buf_d[wr_addr] = wr_data;
    end

    // Byte to send for the current state/step, read from the pre-write buffer.
    always_comb begin
        xfer_cmd  = 1'b1;
        xfer_dat  = 8'h00;
        xfer_lwt  = 1'b0;
        xfer_last = 1'b0;
        buf_idx   = (step_q < 6'd17) ? (step_q - 6'd1) : (step_q - 6'd2);
        if (state_q == S_INIT) begin
            xfer_last = (step_q == 6'd3);
            case (step_q[1:0])
                2'd0:    xfer_dat = 8'h38;
                2'd1:    xfer_dat = 8'h0C;
                2'd2:    xfer_dat = 8'h06;
                default: begin
                    xfer_dat = 8'h01;
                    xfer_lwt = 1'b1;
                end
            endcase
        end else begin
            xfer_last = (step_q == 6'd33);
            if (step_q == 6'd0) begin
                xfer_dat = 8'h80;
            end else if (step_q == 6'd17) begin
                xfer_dat = 8'hC0;
            end else begin
                xfer_cmd = 1'b0;
                xfer_dat = buf_q[buf_idx[4:0]];
            end
        end
    end

    // Top-level sequencing and per-transfer handshake.
    always_comb begin
        state_d     = state_q;
        hs_d        = hs_q;
        step_d      = step_q;
        pwr_cnt_d   = pwr_cnt_q;
        pend_d      = pend_q;
        init_done_d = init_done_q;
        vld_d       = 1'b0;
        cmd_d       = cmd_q;
        dat_d       = dat_q;
        lwt_d       = lwt_q;

        if (state_q == S_FRAME && refresh) pend_d = 1'b1;

        case (state_q)
            S_PWR: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    step_d  = 6'd0;
                    hs_d    = H_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            S_INIT, S_FRAME: begin
                case (hs_q)
                    H_ISSUE: begin
                        if (lcd_ready) begin
                            vld_d = 1'b1;
                            cmd_d = xfer_cmd;
                            dat_d = xfer_dat;
                            lwt_d = xfer_lwt;
                            hs_d  = H_ACK;
                        end
                    end
                    H_ACK: begin
                        if (!lcd_ready) hs_d = H_DONE;
                    end
                    H_DONE: begin
                        if (lcd_ready) begin
                            hs_d = H_ISSUE;
                            if (!xfer_last) begin
                                step_d = step_q + 6'd1;
                            end else if (state_q == S_INIT) begin
                                init_done_d = 1'b1;
                                state_d     = S_FRAME;
                                step_d      = 6'd0;
                                pend_d      = 1'b0;
                            end else if (pend_q || refresh || AUTO_REFRESH) begin
                                step_d = 6'd0;
                                pend_d = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                    default: hs_d = H_ISSUE;
                endcase
            end
            S_IDLE: begin
                if (refresh) begin
                    state_d = S_FRAME;
                    step_d  = 6'd0;
                    hs_d    = H_ISSUE;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = S_PWR;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // State and registered outputs; reset re-runs the whole power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWR;
            hs_q        <= H_ISSUE;
            step_q      <= 6'd0;
            pwr_cnt_q   <= '0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            vld_q       <= 1'b0;
            cmd_q       <= 1'b0;
            dat_q       <= 8'h00;
            lwt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_d;
            step_q      <= step_d;
            pwr_cnt_q   <= pwr_cnt_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            vld_q       <= vld_d;
            cmd_q       <= cmd_d;
            dat_q       <= dat_d;
            lwt_q       <= lwt_d;
        end
    end

    // Buffer storage; reset fills with spaces.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign lcd_cmd   = cmd_q;
    assign lcd_dat   = dat_q;
    assign lcd_vld   = vld_q;
    assign lcd_lwt   = lwt_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mfe_lcd1602_sequencer.sv
// Bench for mfe_lcd1602_sequencer: stub controller, transfer log and a
// buffer-level model of what each frame must contain.
module tb_mfe_lcd1602_sequencer;

    localparam int TP = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       lcd_cmd, lcd_vld, lcd_lwt, busy, init_done;
    logic [7:0] lcd_dat;
    logic       lcd_ready;
    logic       lcd_cmd_a, lcd_vld_a, lcd_lwt_a, busy_a, init_done_a;
    logic [7:0] lcd_dat_a;
    logic       lcd_ready_a;

    logic       hold = 1'b0;
    int         rcnt, rcnt_a;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         rel_cyc;
    logic       prev_vld = 1'b0;

    logic [9:0] log_q[$];
    int         log_cyc[$];
    logic [9:0] loga_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] mbuf[32];

    mfe_lcd1602_sequencer #(.T_PWR(TP), .T_PWR_WIDTH(22), .AUTO_REFRESH(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh(refresh), .lcd_cmd(lcd_cmd), .lcd_dat(lcd_dat), .lcd_vld(lcd_vld),
        .lcd_lwt(lcd_lwt), .lcd_ready(lcd_ready), .busy(busy), .init_done(init_done));

    mfe_lcd1602_sequencer #(.T_PWR(TP), .T_PWR_WIDTH(22), .AUTO_REFRESH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh(1'b0), .lcd_cmd(lcd_cmd_a), .lcd_dat(lcd_dat_a), .lcd_vld(lcd_vld_a),
        .lcd_lwt(lcd_lwt_a), .lcd_ready(lcd_ready_a), .busy(busy_a), .init_done(init_done_a));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub controller: ready drops after a vld, comes back 5 cycles later.
    always @(posedge clk) begin
        if (hold) begin
            lcd_ready <= 1'b0;
            rcnt      <= 0;
        end else if (rst) begin
            lcd_ready <= 1'b1;
            rcnt      <= 0;
        end else if (lcd_ready && lcd_vld) begin
            lcd_ready <= 1'b0;
            rcnt      <= 5;
        end else if (!lcd_ready) begin
            if (rcnt <= 1) lcd_ready <= 1'b1;
            else rcnt <= rcnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            lcd_ready_a <= 1'b1;
            rcnt_a      <= 0;
        end else if (lcd_ready_a && lcd_vld_a) begin
            lcd_ready_a <= 1'b0;
            rcnt_a      <= 5;
        end else if (!lcd_ready_a) begin
            if (rcnt_a <= 1) lcd_ready_a <= 1'b1;
            else rcnt_a <= rcnt_a - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer monitor with protocol checks.
    always @(negedge clk) begin
        if (lcd_vld === 1'b1) begin
            chk("vld_while_ready", {31'd0, lcd_ready}, 32'd1);
            chk("vld_one_cycle", {31'd0, prev_vld}, 32'd0);
            log_q.push_back({lcd_cmd, lcd_lwt, lcd_dat});
            log_cyc.push_back(cyc);
        end
        prev_vld = lcd_vld;
        if (lcd_vld_a === 1'b1) loga_q.push_back({lcd_cmd_a, lcd_lwt_a, lcd_dat_a});
    end

    task automatic push_init();
        exp_q.push_back({1'b1, 1'b0, 8'h38});
        exp_q.push_back({1'b1, 1'b0, 8'h0C});
        exp_q.push_back({1'b1, 1'b0, 8'h06});
        exp_q.push_back({1'b1, 1'b1, 8'h01});
    endtask

    task automatic push_frame();
        for (int line = 0; line < 2; line++) begin
            exp_q.push_back({1'b1, 1'b0, (line == 0) ? 8'h80 : 8'hC0});
            for (int col = 0; col < 16; col++)
                exp_q.push_back({1'b0, 1'b0, mbuf[line * 16 + col]});
        end
    endtask

    task automatic compare_log(input string tag);
        int n;
        chk({tag, "_count"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), {22'd0, log_q[i]}, {22'd0, exp_q[i]});
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mbuf[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rst_vld"}, {31'd0, lcd_vld}, 32'd0);
        chk({tag, "_rst_cmd"}, {31'd0, lcd_cmd}, 32'd0);
        chk({tag, "_rst_dat"}, {24'd0, lcd_dat}, 32'd0);
        chk({tag, "_rst_lwt"}, {31'd0, lcd_lwt}, 32'd0);
        chk({tag, "_rst_init_done"}, {31'd0, init_done}, 32'd0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        log_q.delete();
        log_cyc.delete();
        loga_q.delete();
        exp_q.delete();
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_log(input string tag, input int cnt, input int max_cyc);
        int n = 0;
        while (log_q.size() < cnt && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, {31'd0, log_q.size() >= cnt}, 32'd1);
    endtask

    task automatic wait_loga(input string tag, input int cnt, input int max_cyc);
        int n = 0;
        while (loga_q.size() < cnt && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, {31'd0, loga_q.size() >= cnt}, 32'd1);
    endtask

    initial begin
        int rise;
        int f;
        int tgt;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; refresh = 1'b0;

        // Power-up: wait, init, blank frame.
        do_reset("pwr");
        wait_idle("pwr", 3000);
        chk("pwr_wait", {31'd0, log_cyc.size() > 0 && (log_cyc[0] - rel_cyc) > TP}, 32'd1);
        chk("init_done", {31'd0, init_done}, 32'd1);
        push_init();
        push_frame();
        compare_log("boot");

        // HELLO / W frame.
        wr(5'd0, 8'h48); wr(5'd1, 8'h45); wr(5'd2, 8'h4C); wr(5'd3, 8'h4C); wr(5'd4, 8'h4F);
        wr(5'd16, 8'h57);
        pulse_refresh();
        wait_idle("hello", 3000);
        push_frame();
        compare_log("hello");

        // Random buffer contents.
        for (int k = 0; k < 8; k++) wr(5'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
        pulse_refresh();
        wait_idle("rand", 3000);
        push_frame();
        compare_log("rand");

        // Two refreshes inside one frame give exactly one extra frame.
        pulse_refresh();
        wait_log("dbl_step10", 11, 1000);
        pulse_refresh();
        @(negedge clk);
        pulse_refresh();
        wait_idle("dbl", 6000);
        push_frame();
        push_frame();
        compare_log("dbl");

        // Ready held low after the power wait.
        hold = 1'b1;
        do_reset("hold");
        repeat (TP + 200) @(negedge clk);
        chk("hold_no_vld", log_q.size(), 0);
        hold = 1'b0;
        rise = -1;
        for (int n = 0; n < 50 && log_q.size() == 0; n++) begin
            @(negedge clk);
            if (lcd_ready === 1'b1 && rise < 0) rise = cyc;
        end
        chk("hold_first_vld_gap", (log_cyc.size() > 0) ? log_cyc[0] - rise : -1, 1);
        wait_idle("hold", 3000);
        push_init();
        push_frame();
        compare_log("hold");

        // Reset in the middle of a frame.
        wr(5'd0, 8'h48); wr(5'd1, 8'h49); wr(5'd31, 8'h5A);
        pulse_refresh();
        wait_log("mid_step20", 21, 1000);
        do_reset("mid");
        wait_idle("mid", 3000);
        chk("mid_pwr_wait", {31'd0, log_cyc.size() > 0 && (log_cyc[0] - rel_cyc) > TP}, 32'd1);
        push_init();
        push_frame();
        compare_log("mid");

        // Auto-refresh instance picks up a mid-frame write without refresh.
        wait_loga("auto_mid", 4 + 34 + 10, 2000);
        f = (loga_q.size() - 4) / 34 + 1;
        wr(5'd31, 8'h41);
        tgt = 4 + 34 * f + 34;
        wait_loga("auto_next", tgt, 3000);
        chk("auto_next_start", (loga_q.size() >= tgt) ? {22'd0, loga_q[tgt - 34]} : 32'hFFFF, {22'd0, 10'h280});
        chk("auto_last_byte", (loga_q.size() >= tgt) ? {22'd0, loga_q[tgt - 1]} : 32'hFFFF, {22'd0, 10'h041});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfe_lcd1602_sequencer.md
Name: mfe_lcd1602_sequencer

Overview:
Upstream command source for mfe_lcd1602_controller. After power-up it waits the HD44780 settling time and issues the init sequence. It then renders a 32-byte character buffer (2 lines x 16) to the display on each refresh request. It drives the controller's cmd/dat/vld/lwt inputs and paces itself on the controller's ready output.

Parameters:
T_PWR, 4000000, power-on wait in clk cycles (40 ms at 100 MHz)
T_PWR_WIDTH, 22, bit width of power-on counter
AUTO_REFRESH, 0, 1 = start a new frame immediately after each frame completes

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset; clock clk
wr_en  input  1  buffer write strobe
wr_addr  input  5  buffer address; 0-15 = line 1 col 0-15, 16-31 = line 2
wr_data  input  8  character code
refresh  input  1  single-cycle request to redraw the display from the buffer
lcd_cmd  output  1  to controller cmd; 1 = instruction, 0 = data
lcd_dat  output  8  to controller dat
lcd_vld  output  1  to controller vld; one-cycle pulse
lcd_lwt  output  1  to controller lwt; 1 = long wait after this transfer
lcd_ready  input  1  from controller ready
busy  output  1  high unless in S_IDLE
init_done  output  1  sticky high once the init sequence completes

Behaviour:
- Reset values:
  - lcd_vld=0, lcd_cmd=0, lcd_dat=0x00, lcd_lwt=0, init_done=0, busy=1.
  - State S_PWR with power counter cleared.
  - Refresh-pending flag cleared; all 32 buffer bytes set to 0x20.
- Buffer write:
  - wr_en writes buf[wr_addr] at the clock edge. Accepted in every state, including during reset release.
  - If a write and a transfer-issue hit the same address in the same cycle, the old byte is sent.
- Top-level states:
  - S_PWR: counts to T_PWR-1, then goes to S_INIT with step=0.
  - S_INIT: steps 0-3 issue, in order:
    - 0x38 (cmd=1, lwt=0)
    - 0x0C (cmd=1, lwt=0)
    - 0x06 (cmd=1, lwt=0)
    - 0x01 (cmd=1, lwt=1)
    - After step 3 completes: init_done<=1, go to S_FRAME with step=0.
  - S_FRAME: steps 0-33:
    - step 0: 0x80 (cmd=1)
    - steps 1-16: buf[step-1] (cmd=0)
    - step 17: 0xC0 (cmd=1)
    - steps 18-33: buf[step-2] (cmd=0)
    - lwt=0 on all frame steps.
    - After step 33 completes: go to S_FRAME step 0 if pending or AUTO_REFRESH, else S_IDLE.
  - S_IDLE: busy=0. refresh=1 goes to S_FRAME step 0.
- Per-transfer handshake (sub-state machine):
  - H_ISSUE: when lcd_ready=1, drive lcd_cmd/lcd_dat/lcd_lwt and pulse lcd_vld for exactly one cycle, then go to H_ACK.
  - H_ACK: wait for lcd_ready=0.
  - H_DONE: wait for lcd_ready=1, then step advances and the next transfer enters H_ISSUE.
  - lcd_vld is never asserted while lcd_ready=0 or while in H_ACK/H_DONE.
  - lcd_cmd/lcd_dat/lcd_lwt hold their values after the pulse until the next issue.
- Minimum gap between consecutive vld pulses is bounded by the controller; the sequencer adds no delays of its own.
- Refresh handling:
  - refresh during S_PWR/S_INIT: ignored, because a frame always follows init.
  - refresh during S_FRAME: sets pending. Pending is cleared when the next frame starts at step 0.
  - Multiple refreshes during one frame yield exactly one extra frame.
- Reset mid-operation:
  - Returns to S_PWR. The full power wait and init are re-run; the buffer is re-cleared.
  - A transfer in flight is abandoned. The controller is reset by the same rst.

Test Plan:
- Reset, T_PWR=10, stub controller (ready drops 1 cycle after vld, rises 5 cycles later) -> no vld for 10 cycles; then vld pulses 0x38,0x0C,0x06,0x01 (cmd=1; lwt=1 only on 0x01); init_done=1; then 0x80, 16x 0x20 (cmd=0), 0xC0, 16x 0x20; busy=0 after last.
- In idle, write "HELLO" to addr 0-4 and 'W' to addr 16, pulse refresh -> frame sends 0x80, 0x48,0x45,0x4C,0x4C,0x4F, 11x 0x20, 0xC0, 0x57, 15x 0x20.
- Two refresh pulses during frame step 10 -> exactly two complete frames (68 vld pulses), then busy=0.
- Stub holds ready=0 for 200 cycles after power wait -> zero vld pulses in that window; first vld appears the cycle after ready rises.
- Assert rst during S_FRAME step 20 -> vld stops; outputs return to reset values; after T_PWR the init sequence restarts at 0x38 and the frame shows all 0x20.
- AUTO_REFRESH=1 with write buf[31]=0x41 mid-frame -> the next frame's final data byte is 0x41 with no refresh pulse.
